// File: rtl/peripheral_spi_fifo_if.sv
// J1 I/O bus slice seen by peripheral_spi_fifo: select, strobes, 4-bit address, 16-bit data.
interface peripheral_spi_fifo_if;
  logic [15:0] d_in;
  logic        cs;
  logic [3:0]  addr;
  logic        rd;
  logic        wr;
  logic [15:0] d_out;

  modport master (output d_in, cs, addr, rd, wr, input d_out);
  modport slave  (input d_in, cs, addr, rd, wr, output d_out);
endinterface

// File: rtl/peripheral_spi_fifo.sv
// FIFO-buffered SPI master for the J1 I/O bus: TX/RX FIFOs, runtime divider, CPOL/CPHA, auto/forced ss.
// Optional feature macro SPI_IRQ_EN adds the irq port and the IEN register at 0xA.
module peripheral_spi_fifo #(
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 8,
  parameter int DIV_RST    = 49
) (
  input  logic                 clk,
  input  logic                 reset,
  peripheral_spi_fifo_if.slave bus,
  output logic                 sclk,
  output logic                 mosi,
  input  logic                 miso,
  output logic                 ss
`ifdef SPI_IRQ_EN
  ,
  output logic                 irq
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = $clog2(2 * DW);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LEAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_TRAIL = 2'd3;
  localparam logic [AW:0]      PTR_ONE   = (AW + 1)'(1);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_ZERO  = DIV_W'(0);
  localparam logic [EW-1:0]    EDGE_ONE  = EW'(1);
  localparam logic [EW-1:0]    EDGE_LAST = EW'(2 * DW - 1);

  logic [DW-1:0]    tx_mem_r [FIFO_DEPTH];
  logic [DW-1:0]    rx_mem_r [FIFO_DEPTH];
  logic [AW:0]      tx_wp_r, tx_rp_r, rx_wp_r, rx_rp_r;
  logic [1:0]       state_r;
  logic [3:0]       ctrl_r;
  logic [DIV_W-1:0] div_r, div_l_r, hp_r;
  logic             cpol_l_r, cpha_l_r;
  logic [EW-1:0]    edge_r;
  logic [DW-1:0]    tx_sh_r, rx_sh_r;
  logic             txovf_r, rxovf_r;
  logic [15:0]      d_out_r;
  logic             sclk_r, mosi_r, ss_r;
  logic [15:0]      rdata_s;
  logic [DW-1:0]    tx_head_s;
  logic             unused_s;

  logic wr_s, rd_s, tx_full_s, tx_empty_s, rx_full_s, rx_empty_s, busy_s;
  logic tx_push_s, tx_ovf_set_s, rx_pop_s, start_s, rx_req_s, rx_push_s, rx_ovf_set_s;
  logic stat_wr_s;

  assign wr_s       = bus.cs && bus.wr;
  assign rd_s       = bus.cs && bus.rd;
  assign tx_empty_s = (tx_wp_r == tx_rp_r);
  assign tx_full_s  = (tx_wp_r[AW] != tx_rp_r[AW]) && (tx_wp_r[AW-1:0] == tx_rp_r[AW-1:0]);
  assign rx_empty_s = (rx_wp_r == rx_rp_r);
  assign rx_full_s  = (rx_wp_r[AW] != rx_rp_r[AW]) && (rx_wp_r[AW-1:0] == rx_rp_r[AW-1:0]);
  assign busy_s     = (state_r != ST_IDLE) || !tx_empty_s;
  assign tx_head_s  = tx_mem_r[tx_rp_r[AW-1:0]];
  assign unused_s   = ^bus.d_in;

  assign tx_push_s    = wr_s && (bus.addr == 4'h0) && !tx_full_s;
  assign tx_ovf_set_s = wr_s && (bus.addr == 4'h0) && tx_full_s;
  assign stat_wr_s    = wr_s && (bus.addr == 4'h4);
  assign rx_pop_s     = rd_s && (bus.addr == 4'h6) && !rx_empty_s;
  // A new word starts from IDLE, or straight out of TRAIL to keep ss low between words
  assign start_s      = !tx_empty_s && ((state_r == ST_IDLE) ||
                                        ((state_r == ST_TRAIL) && (hp_r == DIV_ZERO)));
  assign rx_req_s     = (state_r == ST_SHIFT) && (hp_r == DIV_ZERO) && (edge_r == EDGE_LAST);
  assign rx_push_s    = rx_req_s && (!rx_full_s || rx_pop_s);
  assign rx_ovf_set_s = rx_req_s && rx_full_s && !rx_pop_s;

`ifdef SPI_IRQ_EN
  logic [2:0] ien_r;
  logic       irq_r;
  assign irq = irq_r;
`endif

  assign sclk      = sclk_r;
  assign mosi      = mosi_r;
  assign ss        = ss_r;
  assign bus.d_out = d_out_r;

  // Read-data mux for the register map
  always_comb begin
    rdata_s = 16'h0000;
    case (bus.addr)
      4'h2:    rdata_s = 16'(ctrl_r);
      4'h4:    rdata_s = {9'd0, rxovf_r, txovf_r, rx_empty_s, rx_full_s, tx_empty_s, tx_full_s, busy_s};
      4'h6:    rdata_s = rx_empty_s ? 16'h0000 : 16'(rx_mem_r[rx_rp_r[AW-1:0]]);
      4'h8:    rdata_s = 16'(div_r);
`ifdef SPI_IRQ_EN
      4'hA:    rdata_s = {13'd0, ien_r};
`endif
      default: rdata_s = 16'h0000;
    endcase
  end

  // Bus-visible registers, sticky flags and registered read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_r  <= 4'h0;
      div_r   <= DIV_W'(DIV_RST);
      txovf_r <= 1'b0;
      rxovf_r <= 1'b0;
      d_out_r <= 16'h0000;
    end else begin
      if (wr_s && (bus.addr == 4'h2)) ctrl_r <= bus.d_in[3:0];
      if (wr_s && (bus.addr == 4'h8)) div_r <= bus.d_in[DIV_W-1:0];
      if (tx_ovf_set_s) txovf_r <= 1'b1;
      else if (stat_wr_s && bus.d_in[5]) txovf_r <= 1'b0;
      else txovf_r <= txovf_r;
      if (rx_ovf_set_s) rxovf_r <= 1'b1;
      else if (stat_wr_s && bus.d_in[6]) rxovf_r <= 1'b0;
      else rxovf_r <= rxovf_r;
      if (rd_s) d_out_r <= rdata_s;
      else d_out_r <= d_out_r;
    end
  end

`ifdef SPI_IRQ_EN
  // Interrupt enable register and registered level interrupt
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ien_r <= 3'b000;
      irq_r <= 1'b0;
    end else begin
      if (wr_s && (bus.addr == 4'hA)) ien_r <= bus.d_in[2:0];
      irq_r <= |(ien_r & {txovf_r | rxovf_r, tx_empty_s, !rx_empty_s});
    end
  end
`endif

  // FIFO pointers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wp_r <= '0;
      tx_rp_r <= '0;
      rx_wp_r <= '0;
      rx_rp_r <= '0;
    end else begin
      if (tx_push_s) tx_wp_r <= tx_wp_r + PTR_ONE;
      if (start_s)   tx_rp_r <= tx_rp_r + PTR_ONE;
      if (rx_push_s) rx_wp_r <= rx_wp_r + PTR_ONE;
      if (rx_pop_s)  rx_rp_r <= rx_rp_r + PTR_ONE;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (tx_push_s) tx_mem_r[tx_wp_r[AW-1:0]] <= bus.d_in[DW-1:0];
    if (rx_push_s) rx_mem_r[rx_wp_r[AW-1:0]] <= rx_sh_r;
  end

  // Transfer engine: word framing, sclk generation, shift and sample
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      sclk_r   <= 1'b0;
      mosi_r   <= 1'b0;
      ss_r     <= 1'b1;
      cpol_l_r <= 1'b0;
      cpha_l_r <= 1'b0;
      div_l_r  <= DIV_ZERO;
      hp_r     <= DIV_ZERO;
      edge_r   <= '0;
      tx_sh_r  <= '0;
      rx_sh_r  <= '0;
    end else if (start_s) begin
      state_r  <= ST_LEAD;
      cpha_l_r <= ctrl_r[0];
      cpol_l_r <= ctrl_r[1];
      sclk_r   <= ctrl_r[1];
      div_l_r  <= div_r;
      hp_r     <= div_r;
      ss_r     <= 1'b0;
      if (!ctrl_r[0]) begin
        mosi_r  <= tx_head_s[DW-1];
        tx_sh_r <= {tx_head_s[DW-2:0], 1'b0};
      end else begin
        tx_sh_r <= tx_head_s;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          sclk_r <= ctrl_r[1];
          ss_r   <= ~(ctrl_r[2] | ctrl_r[3]);
        end
        ST_LEAD: begin
          if (hp_r == DIV_ZERO) begin
            state_r <= ST_SHIFT;
            hp_r    <= div_l_r;
            edge_r  <= '0;
            sclk_r  <= ~cpol_l_r;
            if (cpha_l_r) begin
              mosi_r  <= tx_sh_r[DW-1];
              tx_sh_r <= {tx_sh_r[DW-2:0], 1'b0};
            end else begin
              rx_sh_r <= {rx_sh_r[DW-2:0], miso};
            end
          end else begin
            hp_r <= hp_r - DIV_ONE;
          end
        end
        ST_SHIFT: begin
          if (hp_r != DIV_ZERO) begin
            hp_r <= hp_r - DIV_ONE;
          end else if (edge_r == EDGE_LAST) begin
            state_r <= ST_TRAIL;
            hp_r    <= div_l_r;
          end else begin
            edge_r <= edge_r + EDGE_ONE;
            hp_r   <= div_l_r;
            sclk_r <= ~sclk_r;
            // Upcoming edge drives mosi when its phase matches CPHA, otherwise it samples miso
            if (edge_r[0] == cpha_l_r) begin
              mosi_r  <= tx_sh_r[DW-1];
              tx_sh_r <= {tx_sh_r[DW-2:0], 1'b0};
            end else begin
              rx_sh_r <= {rx_sh_r[DW-2:0], miso};
            end
          end
        end
        ST_TRAIL: begin
          if (hp_r == DIV_ZERO) begin
            state_r <= ST_IDLE;
            ss_r    <= ~(ctrl_r[2] | ctrl_r[3]);
          end else begin
            hp_r <= hp_r - DIV_ONE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_peripheral_spi_fifo.sv
// Self-checking bench for peripheral_spi_fifo: register table, directed corner sequences, random loopback batches.
module tb_peripheral_spi_fifo;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk, mosi, miso, ss;
  int   checks = 0;
  int   errors = 0;

  peripheral_spi_fifo_if bus ();

`ifdef SPI_IRQ_EN
  logic irq;
  peripheral_spi_fifo dut (.clk(clk), .reset(rst_n), .bus(bus), .sclk(sclk), .mosi(mosi),
                           .miso(miso), .ss(ss), .irq(irq));
`else
  peripheral_spi_fifo dut (.clk(clk), .reset(rst_n), .bus(bus), .sclk(sclk), .mosi(mosi),
                           .miso(miso), .ss(ss));
`endif

  always #5 clk = ~clk;
  assign miso = mosi;

  // SPI line monitor: rebuilds words from mosi at the sampling edge of the active mode
  int          edges_total = 0;
  int          ss_falls = 0;
  int          mon_div = 0;
  logic        mon_cpol = 1'b0;
  logic        mon_cpha = 1'b0;
  logic [DW-1:0] mon_q[$];
  bit          bad_q[$];

  initial begin
    int   cyc, last_edge, edge_cnt;
    logic prev_sclk, prev_ss, leading;
    logic [DW-1:0] word;
    bit   bad;
    cyc = 0; last_edge = 0; edge_cnt = 0; prev_sclk = 1'b0; prev_ss = 1'b1; word = '0; bad = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        edge_cnt = 0; bad = 1'b0;
      end else begin
        if (prev_ss === 1'b1 && ss === 1'b0) ss_falls++;
        if (sclk !== prev_sclk && ss === 1'b0) begin
          leading = (sclk != mon_cpol);
          if (edge_cnt > 0 && (cyc - last_edge) != mon_div + 1) bad = 1'b1;
          last_edge = cyc;
          edge_cnt++;
          edges_total++;
          if (leading == !mon_cpha) word = {word[DW-2:0], mosi};
          if (edge_cnt == 2 * DW) begin
            mon_q.push_back(word);
            bad_q.push_back(bad);
            edge_cnt = 0; bad = 1'b0;
          end
        end
      end
      prev_sclk = sclk;
      prev_ss = ss;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    bus.cs = 1'b1; bus.wr = 1'b1; bus.addr = a; bus.d_in = d;
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.wr = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [15:0] d);
    @(posedge clk); #1;
    bus.cs = 1'b1; bus.rd = 1'b1; bus.addr = a;
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.rd = 1'b0;
    d = bus.d_out;
  endtask

  task automatic read_chk(input string name, input logic [3:0] a, input logic [15:0] exp);
    logic [15:0] d;
    bus_read(a, d);
    chk(name, {16'h0000, d}, {16'h0000, exp});
  endtask

  task automatic wait_idle(input int limit);
    logic [15:0] s;
    s = 16'h0001;
    for (int i = 0; i < limit && s[0]; i++) bus_read(4'h4, s);
    chk("busy timeout", {31'd0, s[0]}, 32'd0);
  endtask

  task automatic chk_mon(input logic [DW-1:0] exp);
    if (mon_q.size() == 0) begin
      chk("mosi word missing", 32'd0, 32'd1);
    end else begin
      chk("mosi word", {24'd0, mon_q.pop_front()}, {24'd0, exp});
      chk("sclk half-period", {31'd0, bad_q.pop_front()}, 32'd0);
    end
  endtask

  task automatic set_mode(input logic [3:0] ctrl, input int div);
    bus_write(4'h2, {12'h000, ctrl});
    bus_write(4'h8, 16'(div));
    mon_cpha = ctrl[0]; mon_cpol = ctrl[1]; mon_div = div;
    mon_q.delete(); bad_q.delete();
  endtask

  typedef struct {
    logic [3:0]  addr;
    logic        do_wr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  initial begin
    vec_t vecs[8];
    logic [15:0] d;
    logic [DW-1:0] exp_q[$];
    int   f0, e0, target, n;

    bus.cs = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = 4'h0; bus.d_in = 16'h0000;
    vecs[0] = '{4'h2, 1'b1, 16'h0005, 16'h0005};
    vecs[1] = '{4'h2, 1'b1, 16'hFFF0, 16'h0000};
    vecs[2] = '{4'h8, 1'b1, 16'h1203, 16'h0003};
    vecs[3] = '{4'hC, 1'b1, 16'hFFFF, 16'h0000};
`ifdef SPI_IRQ_EN
    vecs[4] = '{4'hA, 1'b1, 16'hFFFF, 16'h0007};
`else
    vecs[4] = '{4'hA, 1'b1, 16'hFFFF, 16'h0000};
`endif
    vecs[5] = '{4'hA, 1'b1, 16'h0000, 16'h0000};
    vecs[6] = '{4'h4, 1'b0, 16'h0000, 16'h0014};
    vecs[7] = '{4'h6, 1'b0, 16'h0000, 16'h0000};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset ss", {31'd0, ss}, 32'd1);
    chk("reset sclk", {31'd0, sclk}, 32'd0);
    chk("reset mosi", {31'd0, mosi}, 32'd0);
    chk("reset d_out", {16'h0000, bus.d_out}, 32'd0);

    // Reset held mid-word aborts it without pushing anything
    bus_write(4'h0, 16'h00C3);
    repeat (300) @(posedge clk);
    chk("word in progress ss", {31'd0, ss}, 32'd0);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid-reset ss", {31'd0, ss}, 32'd1);
    chk("mid-reset sclk", {31'd0, sclk}, 32'd0);
    rst_n = 1'b1;
    read_chk("post-reset STATUS", 4'h4, 16'h0014);
    read_chk("post-reset CLKDIV", 4'h8, 16'd49);
    read_chk("post-reset RXDATA", 4'h6, 16'h0000);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].do_wr) bus_write(vecs[i].addr, vecs[i].wdata);
      bus_read(vecs[i].addr, d);
      checks++;
      if (d !== vecs[i].exp) begin
        errors++;
        $display("FAIL reg vector %0d addr 0x%0h: got 0x%0h, expected 0x%0h", i, vecs[i].addr, d, vecs[i].exp);
      end
    end

    // Mode 0, divider 0, single word
    set_mode(4'h0, 0);
    f0 = ss_falls; e0 = edges_total;
    bus_write(4'h0, 16'h00A5);
    wait_idle(200);
    chk_mon(8'hA5);
    chk("mode0 sclk edges", 32'(edges_total - e0), 32'd16);
    chk("mode0 ss frames", 32'(ss_falls - f0), 32'd1);
    chk("mode0 ss idle", {31'd0, ss}, 32'd1);
    read_chk("mode0 RXDATA", 4'h6, 16'h00A5);

    // Mode 3, three back-to-back words
    set_mode(4'h3, 0);
    chk("mode3 idle sclk", {31'd0, sclk}, 32'd1);
    f0 = ss_falls;
    bus_write(4'h0, 16'h0012);
    bus_write(4'h0, 16'h0034);
    bus_write(4'h0, 16'h0056);
    wait_idle(500);
    chk("mode3 ss frames", 32'(ss_falls - f0), 32'd1);
    chk("mode3 idle sclk after", {31'd0, sclk}, 32'd1);
    chk_mon(8'h12); chk_mon(8'h34); chk_mon(8'h56);
    read_chk("mode3 RX0", 4'h6, 16'h0012);
    read_chk("mode3 RX1", 4'h6, 16'h0034);
    read_chk("mode3 RX2", 4'h6, 16'h0056);

    // TX and RX overflow with a slow clock
    set_mode(4'h0, 255);
    for (int i = 1; i <= 6; i++) bus_write(4'h0, 16'(i * 17));
    read_chk("ovf STATUS busy", 4'h4, 16'h0033);
    wait_idle(20000);
    read_chk("ovf STATUS done", 4'h4, 16'h006C);
    bus_write(4'h4, 16'h0060);
    read_chk("ovf STATUS cleared", 4'h4, 16'h000C);
    for (int i = 1; i <= 4; i++) read_chk("ovf RX word", 4'h6, 16'(i * 17));
    read_chk("ovf drained STATUS", 4'h4, 16'h0014);
    read_chk("empty RXDATA", 4'h6, 16'h0000);

    // RX read landing on the same edge as a push into a full RX
    set_mode(4'h0, 3);
    for (int i = 0; i < 4; i++) bus_write(4'h0, 16'h0081 + 16'(i));
    wait_idle(1000);
    target = edges_total + 16;
    bus_write(4'h0, 16'h0085);
    for (int i = 0; i < 2000 && edges_total < target; i++) @(posedge clk);
    chk("edge wait", {31'd0, edges_total >= target}, 32'd1);
    repeat (2) @(posedge clk);
    #1 bus.cs = 1'b1; bus.rd = 1'b1; bus.addr = 4'h6;
    @(posedge clk);
    #1 bus.cs = 1'b0; bus.rd = 1'b0;
    chk("coincident RX read", {16'h0000, bus.d_out}, 32'h0081);
    wait_idle(500);
    read_chk("coincident no rxovf", 4'h4, 16'h000C);
    for (int i = 2; i <= 5; i++) read_chk("coincident RX word", 4'h6, 16'h0080 + 16'(i));

`ifdef SPI_IRQ_EN
    set_mode(4'h0, 0);
    bus_write(4'hA, 16'h0001);
    chk("irq quiet", {31'd0, irq}, 32'd0);
    bus_write(4'h0, 16'h005A);
    for (int i = 0; i < 200 && irq !== 1'b1; i++) @(posedge clk);
    chk("irq raised", {31'd0, irq}, 32'd1);
    read_chk("irq RXDATA", 4'h6, 16'h005A);
    repeat (2) @(posedge clk);
    chk("irq dropped", {31'd0, irq}, 32'd0);
    bus_write(4'hA, 16'h0000);
`endif

    // Random batches against a queue model of the loopback link
    for (int b = 0; b < 8; b++) begin
      set_mode({2'b00, 2'($urandom_range(0, 3))}, $urandom_range(0, 3));
      n = $urandom_range(1, 4);
      exp_q.delete();
      f0 = ss_falls;
      for (int i = 0; i < n; i++) begin
        exp_q.push_back(DW'($urandom));
        bus_write(4'h0, 16'(exp_q[i]));
      end
      wait_idle(1000);
      chk("rand ss frames", 32'(ss_falls - f0), 32'd1);
      for (int i = 0; i < n; i++) begin
        chk_mon(exp_q[i]);
        read_chk("rand RX word", 4'h6, 16'(exp_q[i]));
      end
      read_chk("rand STATUS", 4'h4, 16'h0014);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
